btn_debounce: RTL
=================

Name: btn_debounce

Overview:
Input-side conditioning block for the push-button/LED path. It synchronises a raw, bouncing button pin into the single clock domain and filters it with a stable-time counter. It emits one-cycle press and release event pulses plus a debounced level. It also owns a toggle-on-press LED register, replacing the clockless edge-triggered LED logic with a fully synchronous design.

Parameters:
DEBOUNCE_CYCLES, 270000, clock cycles the synchronised input must stay stable before a change is accepted (10 ms at 27 MHz); legal range >= 1
CNT_WIDTH, 19, width of the stability counter; must satisfy 2**CNT_WIDTH >= DEBOUNCE_CYCLES
ACTIVE_LOW, 1, 1 = pin reads 0 when pressed; 0 = pin reads 1 when pressed

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
btn_in  input  1  raw asynchronous button pin
btn_state  output  1  debounced level, 1 = pressed
press_pulse  output  1  one-cycle pulse when a press is accepted
release_pulse  output  1  one-cycle pulse when a release is accepted
led  output  1  toggles on every accepted press

Behaviour:
- Interface (already decided): one clock, clk; reset rst is synchronous and active-high.
- Reset values: btn_state=0, press_pulse=0, release_pulse=0, led=0, state=RELEASED, cnt=0. Both synchroniser flops reset to the released pin level (ACTIVE_LOW ? 1 : 0).
- Synchroniser: 2-flop chain on btn_in. The normalised signal is pressed_s = sync2 XOR ACTIVE_LOW (1 = pressed).
- FSM (2-bit), four states:
  - RELEASED: if pressed_s=1, go to CONFIRM_PRESS and set cnt=0.
  - CONFIRM_PRESS: if pressed_s=0, return to RELEASED (bounce; no event). Else if cnt==DEBOUNCE_CYCLES-1, go to PRESSED. Else cnt++.
  - PRESSED: if pressed_s=0, go to CONFIRM_RELEASE and set cnt=0.
  - CONFIRM_RELEASE: mirror of CONFIRM_PRESS. Abort to PRESSED if pressed_s=1; go to RELEASED on cnt==DEBOUNCE_CYCLES-1.
- Outputs, all registered:
  - press_pulse is high for exactly the one cycle after the CONFIRM_PRESS→PRESSED edge.
  - release_pulse is high for exactly the one cycle after the CONFIRM_RELEASE→RELEASED edge.
  - btn_state=1 in PRESSED and CONFIRM_RELEASE, 0 otherwise; it changes on the same edge as the corresponding pulse.
  - led inverts on the same edge that raises press_pulse; releases never affect led.
- Latency: after btn_in settles, the event is registered on the (DEBOUNCE_CYCLES+3)th rising edge. Edge 1 is the first edge that samples the new level. The breakdown is 2 sync + 1 state entry + DEBOUNCE_CYCLES count.
- Counter: never exceeds DEBOUNCE_CYCLES-1, so there is no wrap. It is cleared on entry to each CONFIRM state.
- Glitches shorter than DEBOUNCE_CYCLES+1 synchronised cycles produce no pulse and no led change.
- press_pulse and release_pulse are never high in the same cycle. At most one event is possible per DEBOUNCE_CYCLES+1 cycles.
- Reset mid-confirmation aborts with no pulse.
- If the button is held through reset, it is detected as a fresh press DEBOUNCE_CYCLES+3 edges after rst deasserts. In that case led goes to 1.
- DEBOUNCE_CYCLES=1 is legal: a CONFIRM state lasts one cycle.

Decomposition:
- Shared package btn_defs holds:
  - the state encodings RELEASED=2'd0, CONFIRM_PRESS=2'd1, PRESSED=2'd2, CONFIRM_RELEASE=2'd3;
  - the default DEBOUNCE_CYCLES constant.
- One sub-module, sync_2ff: a parameterised reset value and a 1-bit two-flop synchroniser, reused for every future asynchronous pin.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4 and ACTIVE_LOW=1.
1. Reset: rst=1 for 3 cycles, btn_in=1 -> all outputs 0 during and after reset, no pulses for 20 cycles.
2. Clean press: btn_in 1→0 held 20 cycles -> press_pulse high for exactly one cycle, registered on the 7th edge after the change; btn_state=1 and led 0→1 on that same edge.
3. Bounce: btn_in 0 for 3 cycles, 1 for 2, 0 for 2, 1 for 2, then 0 held -> exactly one press_pulse, 7 edges after the final falling change; led toggles once.
4. Release: from pressed, btn_in 0→1 held -> release_pulse one cycle on the 7th edge; btn_state→0; led unchanged.
5. Two full press/release cycles -> exactly 2 press_pulse and 2 release_pulse; led ends at 0; no pulse pair ever overlaps.
6. Reset mid-operation: assert rst for 1 cycle while in CONFIRM_PRESS with cnt=2 and btn_in held 0 -> no pulse during the abort; led=0; press_pulse on the 7th edge after rst deasserts; led→1.

Source files
------------

// File: rtl/btn_debounce_pkg.sv
// Shared definitions for the button debounce path: FSM state encodings and
// the default stability time.
package btn_defs;

  typedef enum logic [1:0] {
    RELEASED        = 2'd0,
    CONFIRM_PRESS   = 2'd1,
    PRESSED         = 2'd2,
    CONFIRM_RELEASE = 2'd3
  } btn_fsm_e;

  // 10 ms at 27 MHz
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 270000;

endpackage

// File: rtl/btn_debounce_sync_2ff.sv
// Generic 1-bit two-flop synchroniser with a parameterised reset level, for
// bringing asynchronous pins into the clk domain.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/btn_debounce.sv
// Push-button conditioning: synchronise, debounce with a stable-time counter,
// emit press/release pulses and a debounced level, and toggle an LED on press.
module btn_debounce
  import btn_defs::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned CNT_WIDTH       = 19,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_state,
  output logic press_pulse,
  output logic release_pulse,
  output logic led
);

  localparam logic                 RELEASED_PIN = logic'(ACTIVE_LOW);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST     = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                 btn_sync;
  logic                 pressed_s;
  btn_fsm_e             state, state_next;
  logic [CNT_WIDTH-1:0] cnt, cnt_next;
  logic                 press_evt, release_evt;

  sync_2ff #(
    .RESET_VAL(RELEASED_PIN)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (btn_in),
    .q  (btn_sync)
  );

  assign pressed_s = btn_sync ^ RELEASED_PIN;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      RELEASED: begin
        if (pressed_s) begin
          state_next = CONFIRM_PRESS;
          cnt_next   = '0;
        end
      end
      CONFIRM_PRESS: begin
        if (!pressed_s)            state_next = RELEASED;
        else if (cnt == CNT_LAST)  state_next = PRESSED;
        else                       cnt_next   = cnt + 1'b1;
      end
      PRESSED: begin
        if (!pressed_s) begin
          state_next = CONFIRM_RELEASE;
          cnt_next   = '0;
        end
      end
      CONFIRM_RELEASE: begin
        if (pressed_s)             state_next = PRESSED;
        else if (cnt == CNT_LAST)  state_next = RELEASED;
        else                       cnt_next   = cnt + 1'b1;
      end
      default: state_next = RELEASED;
    endcase
  end

  assign press_evt   = (state == CONFIRM_PRESS)   && (state_next == PRESSED);
  assign release_evt = (state == CONFIRM_RELEASE) && (state_next == RELEASED);

  // Outputs are registered from the next state so they move on the same edge
  // that the FSM accepts an event.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RELEASED;
      cnt           <= '0;
      btn_state     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      led           <= 1'b0;
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      btn_state     <= (state_next == PRESSED) || (state_next == CONFIRM_RELEASE);
      press_pulse   <= press_evt;
      release_pulse <= release_evt;
      if (press_evt) led <= ~led;
    end
  end

endmodule
